log_afpm_stream: RTL and testbench
==================================

// Module: log_afpm_stream
// PURPOSE
//  Streaming, parametrised successor to the byte-serial logarithmic approximate FP multiplier.
//  Multiplies two IEEE-style floats (EXP_W/MAN_W) in a 3-stage pipeline behind valid/ready.
//  Supports a per-operation mode: Mitchell log-approximate (mode=0) or exact-truncated (mode=1).
//  Handles zero, Inf, NaN, overflow and underflow. Sits between the operand FIFO and the
//  result/error-statistics collector.
// PARAMETERS
//  EXP_W   5                        exponent field width
//  MAN_W   10                       stored mantissa width (hidden bit implicit)
//  TAG_W   4                        opaque tag carried alongside each operation
//  BIAS    (1<<(EXP_W-1))-1         exponent bias (derived; do not override)
//  FP_W    1+EXP_W+MAN_W            word width (derived)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block accepts operands this cycle
//  in_a       in   FP_W   operand A {sign, exp, man}
//  in_b       in   FP_W   operand B
//  in_mode    in   1      0 = Mitchell approximation, 1 = exact truncated product
//  in_tag     in   TAG_W  tag returned with the result
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_p      out  FP_W   product
//  out_tag    out  TAG_W  tag of this product
//  out_flags  out  3      {nan, ovf, unf} for this product
// BEHAVIOUR
//  - Reset (async on rst): all stage-valid bits 0; out_valid=0, out_p=0, out_tag=0, out_flags=0.
//    In-flight operations are discarded. in_ready=1 during and after reset.
//  - Handshake: adv = !out_valid | out_ready; in_ready = adv. All stages shift together on adv.
//    A transfer occurs on in_valid&in_ready. Bubbles advance and are not collapsed.
//    out_p/out_tag/out_flags are held stable while out_valid & !out_ready.
//  - Latency: 3 clk from accept to out_valid (no stall). Throughput: 1 op/clk.
//    Results are returned in order.
//  - S1: register operands, mode and tag. Classify each operand:
//      zero : exp == 0 (subnormals are flushed to zero)
//      inf  : exp == all-ones, man == 0
//      nan  : exp == all-ones, man != 0
//  - S2: sign = Sa^Sb. Esum = Ea + Eb - BIAS, signed, EXP_W+2 bits.
//      mode0: S = Ma + Mb, MAN_W+1 bits.
//      mode1: P = {1,Ma} * {1,Mb}, 2*MAN_W+2 bits.
//  - S3: normalise, then special-case and pack.
//      mode0: c = S[MAN_W]; M = S[MAN_W-1:0].
//      mode1: c = P[2*MAN_W+1]; M = c ? P[2*MAN_W:MAN_W+1] : P[2*MAN_W-1:MAN_W].
//      Truncation only; no rounding. E = Esum + c.
//  - Special-case priority (first match wins):
//      1. any nan, or inf*zero -> canonical NaN {0, all-ones, 1<<(MAN_W-1)}, nan=1.
//      2. any inf -> {sign, all-ones, 0}.
//      3. any zero -> {sign, 0, 0}.
//      4. E >= all-ones -> {sign, all-ones, 0}, ovf=1.
//      5. E <= 0 -> {sign, 0, 0}, unf=1.
//      6. otherwise {sign, E[EXP_W-1:0], M}.
//  - Mode is per operation. Mixed-mode back-to-back streams are legal.
//  - rst asserted mid-stream: the output drops to reset values immediately, with no partial result.
// STRUCTURE
//  - Shared package afpm_pkg: fp_class_t enum {ZERO, NORM, INF, NAN}; canonical-NaN constant;
//    mode encodings (MODE_MITCHELL=0, MODE_EXACT=1); flag bit indices.
//  - One sub-module: afpm_classify (combinational, per operand: class + fields),
//    instantiated twice in S1.
//  - Pipeline registers and the valid/adv chain live in this module.
// TESTING
//  1. FP16 defaults, 0x3C00*0x3C00, mode0 and mode1 -> 0x3C00 both modes, flags 0, out_valid 3 clk after accept.
//  2. 0x3E00*0x3E00 (1.5*1.5): mode0 -> 0x4000; mode1 -> 0x4080 (2.25).
//  3. 0x7BFF*0x7BFF -> 0x7C00, ovf=1. 0x0400*0x0400 -> 0x0000, unf=1. 0xBC00*0x3C00 -> 0xBC00.
//  4. 0x0000*0x7C00 -> 0x7E00, nan=1. 0x7C01*0x3C00 -> 0x7E00. 0xFC00*0x4000 -> 0xFC00.
//  5. Stream 8 tagged ops with out_ready low for 5 clk -> in_ready=0 while the pipe is full;
//     all 8 results arrive in tag order, none lost or duplicated, outputs stable during the stall.
//  6. Assert rst with 3 ops in flight -> out_valid=0 at once. The next op after release
//     returns exactly one result with the correct value.

Source files
------------

// File: rtl/afpm_pkg.sv
// Shared types and constants for the logarithmic approximate FP multiplier.
// Operand classes, mode encodings, flag bit positions and the canonical NaN pattern.
package afpm_pkg;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      NORM = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } fp_class_t;

   localparam logic MODE_MITCHELL = 1'b0;
   localparam logic MODE_EXACT    = 1'b1;

   localparam int FLAG_UNF = 0;
   localparam int FLAG_OVF = 1;
   localparam int FLAG_NAN = 2;
   localparam int FLAG_W   = 3;

   // Canonical quiet NaN {0, all-ones, 1<<(man_w-1)}; callers keep the low word bits.
   function automatic logic [31:0] canon_nan(input int exp_w, input int man_w);
      return 32'(((1 << exp_w) - 1) << man_w) | 32'(1 << (man_w - 1));
   endfunction

endpackage

// File: rtl/afpm_classify.sv
// Splits one float into its fields and classifies it; subnormals are treated as zero.
module afpm_classify
   import afpm_pkg::*;
#(
   parameter  int EXP_W = 5,
   parameter  int MAN_W = 10,
   localparam int FP_W  = 1 + EXP_W + MAN_W
) (
   input  logic [FP_W-1:0]  op,
   output logic             sign,
   output logic [EXP_W-1:0] exp_f,
   output logic [MAN_W-1:0] man_f,
   output fp_class_t        cls
);

   always_comb begin
      sign  = op[FP_W-1];
      exp_f = op[FP_W-2 -: EXP_W];
      man_f = op[MAN_W-1:0];
      if (exp_f == '0)
         cls = ZERO;
      else if (exp_f == '1)
         cls = (man_f == '0) ? INF : NAN;
      else
         cls = NORM;
   end

endmodule

// File: rtl/log_afpm_stream.sv
// Three-stage streaming FP multiplier: Mitchell log-approximate or exact-truncated per op.
// S1 registers classified operands, S2 forms exponent sum and mantissa sum/product, S3 packs.
module log_afpm_stream
   import afpm_pkg::*;
#(
   parameter  int EXP_W = 5,
   parameter  int MAN_W = 10,
   parameter  int TAG_W = 4,
   localparam int BIAS  = (1 << (EXP_W - 1)) - 1,
   localparam int FP_W  = 1 + EXP_W + MAN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FP_W-1:0]   in_a,
   input  logic [FP_W-1:0]   in_b,
   input  logic              in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FP_W-1:0]   out_p,
   output logic [TAG_W-1:0]  out_tag,
   output logic [FLAG_W-1:0] out_flags
);

   localparam int PW = 2 * MAN_W + 2;
   localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W + 2)'(BIAS);
   localparam logic signed [EXP_W+1:0] E_ALL1 = (EXP_W + 2)'((1 << EXP_W) - 1);
   localparam logic [FP_W-1:0] NAN_WORD = FP_W'(canon_nan(EXP_W, MAN_W));

   // Handshake: a transfer happens on valid & ready. The whole pipe, bubbles included,
   // shifts when adv = !out_valid | out_ready; in_ready is adv, so a stalled output freezes all.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   logic             ca_sign, cb_sign;
   logic [EXP_W-1:0] ca_exp, cb_exp;
   logic [MAN_W-1:0] ca_man, cb_man;
   fp_class_t        ca_cls, cb_cls;

   afpm_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
      .op(in_a), .sign(ca_sign), .exp_f(ca_exp), .man_f(ca_man), .cls(ca_cls)
   );
   afpm_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
      .op(in_b), .sign(cb_sign), .exp_f(cb_exp), .man_f(cb_man), .cls(cb_cls)
   );

   logic             s1_valid, s1_mode, s1_sa, s1_sb;
   logic [TAG_W-1:0] s1_tag;
   logic [EXP_W-1:0] s1_ea, s1_eb;
   logic [MAN_W-1:0] s1_ma, s1_mb;
   fp_class_t        s1_ca, s1_cb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_mode  <= MODE_MITCHELL;
         s1_tag   <= '0;
         s1_sa    <= 1'b0;
         s1_sb    <= 1'b0;
         s1_ea    <= '0;
         s1_eb    <= '0;
         s1_ma    <= '0;
         s1_mb    <= '0;
         s1_ca    <= ZERO;
         s1_cb    <= ZERO;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_mode  <= in_mode;
         s1_tag   <= in_tag;
         s1_sa    <= ca_sign;
         s1_sb    <= cb_sign;
         s1_ea    <= ca_exp;
         s1_eb    <= cb_exp;
         s1_ma    <= ca_man;
         s1_mb    <= cb_man;
         s1_ca    <= ca_cls;
         s1_cb    <= cb_cls;
      end
   end

   logic signed [EXP_W+1:0] esum_c;
   logic [MAN_W:0]          sum_c;
   logic [PW-1:0]           prod_c;
   logic                    nan_c, inf_c, zero_c;
   logic                    unused_prod_lo;

   always_comb begin
      esum_c = $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS_S;
      sum_c  = {1'b0, s1_ma} + {1'b0, s1_mb};
      prod_c = PW'({1'b1, s1_ma}) * PW'({1'b1, s1_mb});
      nan_c  = (s1_ca == NAN) || (s1_cb == NAN) ||
               (s1_ca == INF && s1_cb == ZERO) || (s1_ca == ZERO && s1_cb == INF);
      inf_c  = (s1_ca == INF) || (s1_cb == INF);
      zero_c = (s1_ca == ZERO) || (s1_cb == ZERO);
   end

   // Product bits below the kept window are truncated away.
   assign unused_prod_lo = ^prod_c[MAN_W-1:0];

   logic                    s2_valid, s2_mode, s2_sign, s2_nan, s2_inf, s2_zero;
   logic [TAG_W-1:0]        s2_tag;
   logic signed [EXP_W+1:0] s2_esum;
   logic [MAN_W:0]          s2_sum;
   logic [MAN_W+1:0]        s2_ph;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_mode  <= MODE_MITCHELL;
         s2_tag   <= '0;
         s2_sign  <= 1'b0;
         s2_esum  <= '0;
         s2_sum   <= '0;
         s2_ph    <= '0;
         s2_nan   <= 1'b0;
         s2_inf   <= 1'b0;
         s2_zero  <= 1'b0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_mode  <= s1_mode;
         s2_tag   <= s1_tag;
         s2_sign  <= s1_sa ^ s1_sb;
         s2_esum  <= esum_c;
         s2_sum   <= sum_c;
         s2_ph    <= prod_c[PW-1:MAN_W];
         s2_nan   <= nan_c;
         s2_inf   <= inf_c;
         s2_zero  <= zero_c;
      end
   end

   logic                    c_n;
   logic [MAN_W-1:0]        m_n;
   logic signed [EXP_W+1:0] e_n;
   logic [FP_W-1:0]         p_n;
   logic [FLAG_W-1:0]       f_n;

   always_comb begin
      c_n = (s2_mode == MODE_EXACT) ? s2_ph[MAN_W+1] : s2_sum[MAN_W];
      if (s2_mode == MODE_EXACT)
         m_n = c_n ? s2_ph[MAN_W:1] : s2_ph[MAN_W-1:0];
      else
         m_n = s2_sum[MAN_W-1:0];
      e_n = s2_esum + $signed({{(EXP_W + 1){1'b0}}, c_n});
      p_n = {s2_sign, e_n[EXP_W-1:0], m_n};
      f_n = '0;
      if (s2_nan) begin
         p_n           = NAN_WORD;
         f_n[FLAG_NAN] = 1'b1;
      end else if (s2_inf) begin
         p_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (s2_zero) begin
         p_n = {s2_sign, {(FP_W - 1){1'b0}}};
      end else if (e_n >= E_ALL1) begin
         p_n           = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         f_n[FLAG_OVF] = 1'b1;
      end else if (e_n[EXP_W+1] || e_n == E_ALL1 - E_ALL1) begin
         p_n           = {s2_sign, {(FP_W - 1){1'b0}}};
         f_n[FLAG_UNF] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_p     <= '0;
         out_tag   <= '0;
         out_flags <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_p     <= p_n;
            out_tag   <= s2_tag;
            out_flags <= f_n;
         end
      end
   end

endmodule

// File: tb/tb_log_afpm_stream.sv
// Directed bench for log_afpm_stream at FP16 defaults: single ops, specials, stall stream, reset flush.
module tb_log_afpm_stream;

   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int TAG_W = 4;
   localparam int FP_W  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, in_mode, out_valid, out_ready;
   logic [FP_W-1:0]  in_a, in_b, out_p;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [2:0]       out_flags;

   always #5 clk = ~clk;

   log_afpm_stream #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_p(out_p), .out_tag(out_tag), .out_flags(out_flags)
   );

   int vectors     = 0;
   int miscompares = 0;
   logic [FP_W+TAG_W-1:0] exp_q[$];

   // Stream table: a is 1.0 or 2.0, so the product is exact in both modes.
   logic [FP_W-1:0] st_a [8] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h4000,
                                 16'h3C00, 16'h4000, 16'h3C00, 16'h4000};
   logic [FP_W-1:0] st_b [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h3800,
                                 16'hC500, 16'h4880, 16'h3555, 16'h7000};
   logic [FP_W-1:0] st_p [8] = '{16'h3C00, 16'h4400, 16'h4200, 16'h3C00,
                                 16'hC500, 16'h4C80, 16'h3555, 16'h7400};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic mode, input logic [3:0] tag,
                         input logic [15:0] exp_p, input logic [2:0] exp_f);
      int lat;
      @(negedge clk);
      in_a = a; in_b = b; in_mode = mode; in_tag = tag; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      check({name, " latency"}, lat, 3);
      check({name, " p"}, out_p, exp_p);
      check({name, " flags"}, out_flags, exp_f);
      check({name, " tag"}, out_tag, tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent, got, extra;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; in_tag = '0;
      out_ready = 1'b1;
      #2;
      check("rst out_valid", out_valid, 0);
      check("rst in_ready", in_ready, 1);
      check("rst out_p", out_p, 0);
      check("rst out_tag", out_tag, 0);
      check("rst out_flags", out_flags, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op("one_m0",      16'h3C00, 16'h3C00, 1'b0, 4'h1, 16'h3C00, 3'b000);
      run_op("one_m1",      16'h3C00, 16'h3C00, 1'b1, 4'h2, 16'h3C00, 3'b000);
      run_op("1p5_m0",      16'h3E00, 16'h3E00, 1'b0, 4'h3, 16'h4000, 3'b000);
      run_op("1p5_m1",      16'h3E00, 16'h3E00, 1'b1, 4'h4, 16'h4080, 3'b000);
      run_op("ovf",         16'h7BFF, 16'h7BFF, 1'b1, 4'h5, 16'h7C00, 3'b010);
      run_op("unf",         16'h0400, 16'h0400, 1'b0, 4'h6, 16'h0000, 3'b001);
      run_op("neg",         16'hBC00, 16'h3C00, 1'b1, 4'h7, 16'hBC00, 3'b000);
      run_op("zero_inf",    16'h0000, 16'h7C00, 1'b0, 4'h8, 16'h7E00, 3'b100);
      run_op("nan_in",      16'h7C01, 16'h3C00, 1'b1, 4'h9, 16'h7E00, 3'b100);
      run_op("neg_inf",     16'hFC00, 16'h4000, 1'b0, 4'hA, 16'hFC00, 3'b000);
      run_op("zero_norm",   16'h8000, 16'h4000, 1'b1, 4'hB, 16'h8000, 3'b000);

      // Stream of 8 with the output stalled for cycles 3..7 once the pipe is full.
      sent = 0; got = 0;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 8);
         in_valid  = (sent < 8);
         if (sent < 8) begin
            in_a = st_a[sent]; in_b = st_b[sent]; in_mode = sent[1]; in_tag = 4'(sent);
         end
         #1;
         if (cyc >= 3 && cyc <= 7) begin
            check("stall in_ready", in_ready, 0);
            check("stall out_valid", out_valid, 1);
            check("stall held", {out_tag, out_p, 1'b0, out_flags}, {4'h0, 16'h3C00, 4'h0});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
               check("stream unexpected", 1, 0);
            else
               check("stream result", {out_tag, out_p}, exp_q.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({4'(sent), st_p[sent]});
            sent++;
         end
         if (got == 8) break;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("stream count", got, 8);
      check("stream leftover", exp_q.size(), 0);

      // Three ops in flight, then an asynchronous reset mid-cycle.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000; in_mode = i[0]; in_tag = 4'(12 + i);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("pre_rst out_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      check("mid_rst out_valid", out_valid, 0);
      check("mid_rst out_p", out_p, 0);
      check("mid_rst out_tag", out_tag, 0);
      check("mid_rst in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst", 16'h3E00, 16'h3E00, 1'b1, 4'h5, 16'h4080, 3'b000);
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("post_rst extra", extra, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
